// File: rtl/ascon_dec_serial_host.sv
// Host-side driver for the bit-serial Ascon decryption core.
// It loads the core's share buses MSB-first, then waits for ready and deserializes the LSB-first plaintext/tag streams.
module ascon_dec_serial_host #(
  parameter int unsigned K   = 128,
  parameter int unsigned L   = 80,
  parameter int unsigned Y   = 80,
  parameter int unsigned TMO = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_i,
  input  logic [3*K-1:0] key_sh_i,
  input  logic [383:0]   nonce_sh_i,
  input  logic [3*L-1:0] ad_sh_i,
  input  logic [3*Y-1:0] ct_sh_i,
  input  logic [8:0]     rnd_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [Y-1:0]   pt_o,
  output logic [127:0]   tag_o,
  output logic           dut_rst_o,
  output logic [2:0]     keyxSI,
  output logic [2:0]     noncexSI,
  output logic [2:0]     associated_dataxSI,
  output logic [2:0]     cipher_textxSI,
  output logic [6:0]     r_64xSI,
  output logic           r_128xSI,
  output logic           r_ptxSI,
  output logic           decryption_startxSI,
  input  logic           plain_textxS0,
  input  logic           tagxSO,
  input  logic           decryption_readyxSO
);

  localparam int unsigned M0 = (K > 128) ? K : 128;
  localparam int unsigned M1 = (M0 > L) ? M0 : L;
  localparam int unsigned M  = (M1 > Y) ? M1 : Y;
  localparam int unsigned P  = (Y > 128) ? Y : 128;
  localparam int unsigned CW = $clog2(M + 1);
  localparam int unsigned JW = $clog2(P);
  localparam int unsigned WW = $clog2(TMO + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [JW-1:0]   j_q, j_d;
  logic [3*K-1:0]  key_q, key_d;
  logic [383:0]    nonce_q, nonce_d;
  logic [3*L-1:0]  ad_q, ad_d;
  logic [3*Y-1:0]  ct_q, ct_d;
  logic [Y-1:0]    pt_q, pt_d;
  logic [127:0]    tag_q, tag_d;
  logic            dut_rst_q, dut_rst_d;
  logic            err_q, err_d;

  // Latched shares are shifted left each LOAD cycle, so the MSB of every share is the current serial bit
  // and an exhausted share naturally drives zeros.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    j_d       = j_q;
    key_d     = key_q;
    nonce_d   = nonce_q;
    ad_d      = ad_q;
    ct_d      = ct_q;
    pt_d      = pt_q;
    tag_d     = tag_q;
    dut_rst_d = dut_rst_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        dut_rst_d = 1'b1;
        if (req_i) begin
          key_d     = key_sh_i;
          nonce_d   = nonce_sh_i;
          ad_d      = ad_sh_i;
          ct_d      = ct_sh_i;
          cnt_d     = '0;
          wdog_d    = '0;
          dut_rst_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        key_d   = {key_q[3*K-2:2*K], 1'b0, key_q[2*K-2:K], 1'b0, key_q[K-2:0], 1'b0};
        nonce_d = {nonce_q[382:256], 1'b0, nonce_q[254:128], 1'b0, nonce_q[126:0], 1'b0};
        ad_d    = {ad_q[3*L-2:2*L], 1'b0, ad_q[2*L-2:L], 1'b0, ad_q[L-2:0], 1'b0};
        ct_d    = {ct_q[3*Y-2:2*Y], 1'b0, ct_q[2*Y-2:Y], 1'b0, ct_q[Y-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(M)) begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        if (decryption_readyxSO) begin
          j_d     = '0;
          state_d = S_CAPTURE;
        end else if (wdog_q == WW'(TMO - 1)) begin
          err_d     = 1'b1;
          dut_rst_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CAPTURE: begin
        for (int b = 0; b < Y; b++) begin
          if (j_q == JW'(b)) pt_d[b] = plain_textxS0;
        end
        for (int b = 0; b < 128; b++) begin
          if (j_q == JW'(b)) tag_d[b] = tagxSO;
        end
        j_d = j_q + JW'(1);
        if (j_q == JW'(P - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        dut_rst_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        dut_rst_d = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wdog_q    <= '0;
      j_q       <= '0;
      key_q     <= '0;
      nonce_q   <= '0;
      ad_q      <= '0;
      ct_q      <= '0;
      pt_q      <= '0;
      tag_q     <= '0;
      dut_rst_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      j_q       <= j_d;
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      ad_q      <= ad_d;
      ct_q      <= ct_d;
      pt_q      <= pt_d;
      tag_q     <= tag_d;
      dut_rst_q <= dut_rst_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    keyxSI             = '0;
    noncexSI           = '0;
    associated_dataxSI = '0;
    cipher_textxSI     = '0;
    r_64xSI            = '0;
    r_128xSI           = 1'b0;
    r_ptxSI            = 1'b0;
    if (state_q == S_LOAD) begin
      keyxSI             = {key_q[3*K-1], key_q[2*K-1], key_q[K-1]};
      noncexSI           = {nonce_q[383], nonce_q[255], nonce_q[127]};
      associated_dataxSI = {ad_q[3*L-1], ad_q[2*L-1], ad_q[L-1]};
      cipher_textxSI     = {ct_q[3*Y-1], ct_q[2*Y-1], ct_q[Y-1]};
      r_64xSI            = (cnt_q < CW'(64))  ? rnd_i[6:0] : 7'd0;
      r_128xSI           = (cnt_q < CW'(128)) ? rnd_i[7]   : 1'b0;
      r_ptxSI            = (cnt_q < CW'(Y))   ? rnd_i[8]   : 1'b0;
    end
  end

  assign decryption_startxSI = (state_q == S_WAIT);
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign err_o               = err_q;
  assign pt_o                = pt_q;
  assign tag_o               = tag_q;
  assign dut_rst_o           = dut_rst_q;

endmodule

// File: tb/tb_ascon_dec_serial_host.sv
// Directed bench for ascon_dec_serial_host: instance A uses the default widths,
// instance B uses L=40, Y=200, TMO=16 for the watchdog and long-plaintext cases.
module tb_ascon_dec_serial_host;

  logic         clk;
  logic         rst;
  logic [383:0] key_sh;
  logic [383:0] nonce_sh;
  logic [8:0]   rnd;

  logic         a_req, a_pt_s, a_tag_s, a_ready;
  logic [239:0] a_ad;
  logic [239:0] a_ct;
  logic         a_busy, a_done, a_err, a_dut_rst;
  logic [79:0]  a_pt;
  logic [127:0] a_tag;
  logic [2:0]   a_key, a_nonce, a_ad_s, a_ct_s;
  logic [6:0]   a_r64;
  logic         a_r128, a_rpt, a_start;

  logic         b_req, b_pt_s, b_tag_s, b_ready;
  logic [119:0] b_ad;
  logic [599:0] b_ct;
  logic         b_busy, b_done, b_err, b_dut_rst;
  logic [199:0] b_pt;
  logic [127:0] b_tag;
  logic [2:0]   b_key, b_nonce, b_ad_s, b_ct_s;
  logic [6:0]   b_r64;
  logic         b_r128, b_rpt, b_start;

  int passed = 0;
  int total  = 0;

  ascon_dec_serial_host #(.K(128), .L(80), .Y(80), .TMO(4096)) u_dut_a (
    .clk(clk), .rst(rst), .req_i(a_req),
    .key_sh_i(key_sh), .nonce_sh_i(nonce_sh), .ad_sh_i(a_ad), .ct_sh_i(a_ct), .rnd_i(rnd),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .pt_o(a_pt), .tag_o(a_tag),
    .dut_rst_o(a_dut_rst), .keyxSI(a_key), .noncexSI(a_nonce),
    .associated_dataxSI(a_ad_s), .cipher_textxSI(a_ct_s),
    .r_64xSI(a_r64), .r_128xSI(a_r128), .r_ptxSI(a_rpt), .decryption_startxSI(a_start),
    .plain_textxS0(a_pt_s), .tagxSO(a_tag_s), .decryption_readyxSO(a_ready)
  );

  ascon_dec_serial_host #(.K(128), .L(40), .Y(200), .TMO(16)) u_dut_b (
    .clk(clk), .rst(rst), .req_i(b_req),
    .key_sh_i(key_sh), .nonce_sh_i(nonce_sh), .ad_sh_i(b_ad), .ct_sh_i(b_ct), .rnd_i(rnd),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .pt_o(b_pt), .tag_o(b_tag),
    .dut_rst_o(b_dut_rst), .keyxSI(b_key), .noncexSI(b_nonce),
    .associated_dataxSI(b_ad_s), .cipher_textxSI(b_ct_s),
    .r_64xSI(b_r64), .r_128xSI(b_r128), .r_ptxSI(b_rpt), .decryption_startxSI(b_start),
    .plain_textxS0(b_pt_s), .tagxSO(b_tag_s), .decryption_readyxSO(b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rnd = 9'h1FF;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({a_busy, a_done, a_err, a_dut_rst} !== 4'b0001) $display("[TB] FAIL reset_ctrl_a: got %b expected 0001", {a_busy, a_done, a_err, a_dut_rst});
    else passed++;
    total++;
    if ({a_pt, a_tag} !== 208'd0) $display("[TB] FAIL reset_pt_tag_a: got %h expected 0", {a_pt, a_tag});
    else passed++;
    total++;
    if ({a_key, a_nonce, a_ad_s, a_ct_s, a_r64, a_r128, a_rpt, a_start} !== 22'd0)
      $display("[TB] FAIL reset_serial_a: got %h expected 0", {a_key, a_nonce, a_ad_s, a_ct_s, a_r64, a_r128, a_rpt, a_start});
    else passed++;
    total++;
    if ({b_busy, b_done, b_err, b_dut_rst, b_start, b_r64} !== 12'b0001_0_0000000) $display("[TB] FAIL reset_b: got %b expected 000100000000", {b_busy, b_done, b_err, b_dut_rst, b_start, b_r64});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_load_order();
    logic [127:0] rx_key, rx_nonce;
    logic [79:0]  rx_ad, rx_ct;
    logic         extra, start_early;
    logic [19:0]  r_snap;
    rx_key = '0; rx_nonce = '0; rx_ad = '0; rx_ct = '0;
    extra = 1'b0; start_early = 1'b0; r_snap = '0;
    key_sh   = {256'd0, 128'h000102030405060708090A0B0C0D0E0F};
    nonce_sh = {256'd0, 128'h000102030405060708090A0B0C0D0E0F};
    a_ad     = {80'd0, 80'hC3C3_0000_0000_0000_0001, 80'd0};
    a_ct     = {80'hDEAD_BEEF_0000_1111_2222, 80'd0, 80'd0};
    rnd      = 9'h1AB;
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    for (int c = 0; c < 129; c++) begin
      if (c < 128) begin
        rx_key   = {rx_key[126:0], a_key[0]};
        rx_nonce = {rx_nonce[126:0], a_nonce[0]};
      end else begin
        extra = extra | a_key[0] | a_nonce[0];
      end
      if (c < 80) begin
        rx_ad = {rx_ad[78:0], a_ad_s[1]};
        rx_ct = {rx_ct[78:0], a_ct_s[2]};
      end else begin
        extra = extra | a_ad_s[1] | a_ct_s[2];
      end
      extra = extra | a_key[1] | a_key[2] | a_nonce[1] | a_nonce[2] | a_ad_s[0] | a_ad_s[2] | a_ct_s[0] | a_ct_s[1];
      start_early = start_early | a_start;
      if (c == 63)  r_snap[19:13] = a_r64;
      if (c == 64)  r_snap[12:6]  = a_r64;
      if (c == 79)  r_snap[5]     = a_rpt;
      if (c == 80)  r_snap[4]     = a_rpt;
      if (c == 127) r_snap[3]     = a_r128;
      if (c == 128) r_snap[2]     = a_r128;
      if (c == 0)   r_snap[1:0]   = {a_r64[0], a_key[0]};
      step();
    end
    total++;
    if (rx_key !== 128'h000102030405060708090A0B0C0D0E0F) $display("[TB] FAIL key_stream: got %h expected 000102030405060708090a0b0c0d0e0f", rx_key);
    else passed++;
    total++;
    if (rx_nonce !== 128'h000102030405060708090A0B0C0D0E0F) $display("[TB] FAIL nonce_stream: got %h expected 000102030405060708090a0b0c0d0e0f", rx_nonce);
    else passed++;
    total++;
    if ({rx_ad, rx_ct} !== {80'hC3C3_0000_0000_0000_0001, 80'hDEAD_BEEF_0000_1111_2222})
      $display("[TB] FAIL ad_ct_stream: got %h expected c3c300000000000000010xdeadbeef000011112222", {rx_ad, rx_ct});
    else passed++;
    total++;
    if ({extra, start_early} !== 2'b00) $display("[TB] FAIL idle_shares_zero: got %b expected 00", {extra, start_early});
    else passed++;
    total++;
    if (r_snap !== {7'h2B, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) $display("[TB] FAIL rnd_gating: got %h expected %h", r_snap, {7'h2B, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    else passed++;
    total++;
    if ({a_start, a_busy, a_dut_rst, a_r64} !== 10'b110_0000000) $display("[TB] FAIL start_after_129: got %b expected 1100000000", {a_start, a_busy, a_dut_rst, a_r64});
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_decrypt();
    logic [79:0]  pt_exp, sh_pt;
    logic [127:0] tag_exp, sh_tag;
    int n, done_cnt;
    pt_exp  = 80'hA5A5_0000_0000_1234_5678;
    tag_exp = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_CDEF;
    sh_pt = pt_exp; sh_tag = tag_exp; done_cnt = 0;
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    n = 0;
    while (a_start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n !== 129) $display("[TB] FAIL start_latency: got %0d expected 129", n);
    else passed++;
    for (int w = 0; w < 20; w++) begin
      done_cnt += int'(a_done) + int'(a_err);
      step();
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    total++;
    if ({a_start, a_busy} !== 2'b01) $display("[TB] FAIL start_deassert: got %b expected 01", {a_start, a_busy});
    else passed++;
    for (int j = 0; j < 128; j++) begin
      a_pt_s  = sh_pt[0];
      a_tag_s = sh_tag[0];
      sh_pt  = sh_pt >> 1;
      sh_tag = sh_tag >> 1;
      done_cnt += int'(a_done) + int'(a_err);
      step();
    end
    a_pt_s = 1'b0; a_tag_s = 1'b0;
    // 129 LOAD + 21 WAIT + 128 CAPTURE edges after acceptance: DONE is cycle 279 counting the request cycle as 0
    total++;
    if ({a_done, done_cnt} !== {1'b1, 32'd0}) $display("[TB] FAIL done_timing: got done=%b early=%0d expected done=1 early=0", a_done, done_cnt);
    else passed++;
    total++;
    if (a_pt !== pt_exp) $display("[TB] FAIL pt_capture: got %h expected %h", a_pt, pt_exp);
    else passed++;
    total++;
    if (a_tag !== tag_exp) $display("[TB] FAIL tag_capture: got %h expected %h", a_tag, tag_exp);
    else passed++;
    step();
    total++;
    if ({a_done, a_busy, a_dut_rst} !== 3'b001) $display("[TB] FAIL after_done: got %b expected 001", {a_done, a_busy, a_dut_rst});
    else passed++;
  endtask

  task automatic test_rst_mid_load();
    int pulses;
    pulses = 0;
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    repeat (50) step();
    total++;
    if ({a_busy, a_dut_rst, a_r64} !== {1'b1, 1'b0, 7'h2B}) $display("[TB] FAIL mid_load_state: got %b expected 100101011", {a_busy, a_dut_rst, a_r64});
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({a_busy, a_done, a_err, a_dut_rst, a_key, a_nonce, a_ad_s, a_ct_s, a_r64, a_r128, a_rpt, a_start} !== {4'b0001, 22'd0})
      $display("[TB] FAIL abort_outputs: got %h expected %h", {a_busy, a_done, a_err, a_dut_rst, a_key, a_nonce, a_ad_s, a_ct_s, a_r64, a_r128, a_rpt, a_start}, {4'b0001, 22'd0});
    else passed++;
    total++;
    if ({a_pt, a_tag} !== 208'd0) $display("[TB] FAIL abort_clears_pt_tag: got %h expected 0", {a_pt, a_tag});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(a_done) + int'(a_err);
      step();
    end
    total++;
    if (pulses !== 0) $display("[TB] FAIL abort_no_pulse: got %0d expected 0", pulses);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [79:0]  pt2, sh_pt;
    logic [127:0] tag2, sh_tag;
    int n, done_cnt, busy_drop;
    pt2 = 80'h0F0F_1E1E_2D2D_3C3C_4B4B;
    tag2 = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_3210;
    sh_pt = pt2; sh_tag = tag2; done_cnt = 0; busy_drop = 0;
    a_req = 1'b1;
    step();
    n = 0;
    while (a_start !== 1'b1 && n < 300) begin
      busy_drop += int'(!a_busy);
      step();
      n++;
    end
    total++;
    if (n !== 129) $display("[TB] FAIL b2b_start_latency: got %0d expected 129", n);
    else passed++;
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    for (int j = 0; j < 128; j++) begin
      a_pt_s  = sh_pt[0];
      a_tag_s = sh_tag[0];
      sh_pt  = sh_pt >> 1;
      sh_tag = sh_tag >> 1;
      busy_drop += int'(!a_busy);
      done_cnt  += int'(a_done);
      step();
    end
    a_pt_s = 1'b0; a_tag_s = 1'b0;
    total++;
    if ({a_done, done_cnt, busy_drop} !== {1'b1, 32'd0, 32'd0}) $display("[TB] FAIL b2b_single_txn: got done=%b early=%0d drops=%0d expected 1/0/0", a_done, done_cnt, busy_drop);
    else passed++;
    step();
    total++;
    if ({a_busy, a_dut_rst, a_done} !== 3'b010) $display("[TB] FAIL b2b_idle_gap: got %b expected 010", {a_busy, a_dut_rst, a_done});
    else passed++;
    step();
    total++;
    if ({a_busy, a_dut_rst} !== 2'b10) $display("[TB] FAIL b2b_restart: got %b expected 10", {a_busy, a_dut_rst});
    else passed++;
    total++;
    if ({a_pt, a_tag} !== {pt2, tag2}) $display("[TB] FAIL b2b_hold_results: got %h expected %h", {a_pt, a_tag}, {pt2, tag2});
    else passed++;
    a_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int n, w, done_seen;
    done_seen = 0;
    b_req = 1'b1;
    step();
    b_req = 1'b0;
    n = 0;
    while (b_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    total++;
    if (n !== 201) $display("[TB] FAIL b_start_latency: got %0d expected 201", n);
    else passed++;
    w = 0;
    while (b_err !== 1'b1 && w < 40) begin
      done_seen += int'(b_done);
      step();
      w++;
    end
    total++;
    if (w !== 16) $display("[TB] FAIL timeout_cycles: got %0d expected 16", w);
    else passed++;
    total++;
    if ({b_busy, b_dut_rst, b_start, done_seen} !== {3'b010, 32'd0}) $display("[TB] FAIL timeout_state: got busy=%b rst=%b start=%b done=%0d expected 0/1/0/0", b_busy, b_dut_rst, b_start, done_seen);
    else passed++;
    step();
    total++;
    if ({b_err, b_done} !== 2'b00) $display("[TB] FAIL err_one_cycle: got %b expected 00", {b_err, b_done});
    else passed++;
  endtask

  task automatic test_long_y();
    logic [199:0] pt3, sh_pt;
    logic [127:0] tag3, sh_tag;
    int bad_ad, done_cnt;
    pt3  = 200'h5A_0123456789ABCDEF_F0E1D2C3B4A59687_1122334455667788;
    tag3 = 128'hCAFE_BABE_DEAD_BEEF_0102_0304_0506_0708;
    sh_pt = pt3; sh_tag = tag3; bad_ad = 0; done_cnt = 0;
    b_ad = {80'd0, 40'hFF_FFFF_FFFF};
    b_ct = '0;
    b_req = 1'b1;
    step();
    b_req = 1'b0;
    for (int c = 0; c < 201; c++) begin
      if (b_ad_s[0] !== ((c < 40) ? 1'b1 : 1'b0)) bad_ad++;
      step();
    end
    total++;
    if ({b_start, bad_ad} !== {1'b1, 32'd0}) $display("[TB] FAIL ad_len40: got start=%b bad=%0d expected 1/0", b_start, bad_ad);
    else passed++;
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    for (int j = 0; j < 200; j++) begin
      b_pt_s  = sh_pt[0];
      b_tag_s = (j < 128) ? sh_tag[0] : 1'b1;
      sh_pt  = sh_pt >> 1;
      sh_tag = sh_tag >> 1;
      done_cnt += int'(b_done);
      step();
    end
    b_pt_s = 1'b0; b_tag_s = 1'b0;
    total++;
    if ({b_done, done_cnt} !== {1'b1, 32'd0}) $display("[TB] FAIL capture_200: got done=%b early=%0d expected 1/0", b_done, done_cnt);
    else passed++;
    total++;
    if (b_pt !== pt3) $display("[TB] FAIL pt_200: got %h expected %h", b_pt, pt3);
    else passed++;
    total++;
    if (b_tag !== tag3) $display("[TB] FAIL tag_stop_128: got %h expected %h", b_tag, tag3);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    key_sh = '0; nonce_sh = '0; rnd = '0;
    a_req = 1'b0; a_ad = '0; a_ct = '0; a_pt_s = 1'b0; a_tag_s = 1'b0; a_ready = 1'b0;
    b_req = 1'b0; b_ad = '0; b_ct = '0; b_pt_s = 1'b0; b_tag_s = 1'b0; b_ready = 1'b0;
    test_reset();
    test_load_order();
    test_decrypt();
    test_rst_mid_load();
    test_back_to_back();
    test_timeout();
    test_long_y();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
